// File: rtl/ctl_spi_byte_engine.sv
// Byte-level SPI mode-0 slave for the control port.
// Works on refined SCK/CS; double-buffered TX byte, framed RX bytes.
module ctl_spi_byte_engine #(
  parameter int unsigned CNT_W   = 16,
  parameter logic        IDLE_SO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sck,
  input  logic             spi_cs,
  input  logic             spi_si,
  output logic             spi_so,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_first,
  input  logic [7:0]       tx_data,
  input  logic             tx_load,
  output logic             tx_req,
  output logic             tx_underrun,
  output logic             frame_active,
  output logic             frame_end,
  output logic [CNT_W-1:0] byte_count
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e           state_q, state_d;
  logic             sck_q, cs_q;
  logic [2:0]       bit_cnt_q;
  logic [6:0]       rx_shift_q;
  logic [7:0]       tx_shift_q;
  logic [7:0]       buf_q;
  logic             full_q;
  logic             first_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             rx_first_q;
  logic             tx_req_q;
  logic             underrun_q;
  logic             frame_end_q;
  logic [CNT_W-1:0] byte_count_q;

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic act, start, stop, rx_edge, tx_edge, consume;

  assign sck_rise = spi_sck & ~sck_q;
  assign sck_fall = ~spi_sck & sck_q;
  assign cs_fall  = ~spi_cs & cs_q;
  assign cs_rise  = spi_cs & ~cs_q;

  assign act     = (state_q == ACTIVE);
  assign stop    = act & cs_rise;
  assign start   = ~act & cs_fall;
  assign rx_edge = act & ~cs_rise & sck_rise;
  assign tx_edge = act & ~cs_rise & sck_fall;
  // Buffer is consumed at frame start and at each byte boundary
  assign consume = start | (tx_edge & (bit_cnt_q == 3'd0));

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sck_q        <= 1'b0;
      cs_q         <= 1'b1;
      bit_cnt_q    <= 3'd0;
      rx_shift_q   <= 7'd0;
      tx_shift_q   <= 8'hFF;
      buf_q        <= 8'd0;
      full_q       <= 1'b0;
      first_q      <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_first_q   <= 1'b0;
      tx_req_q     <= 1'b0;
      underrun_q   <= 1'b0;
      frame_end_q  <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sck_q       <= spi_sck;
      cs_q        <= spi_cs;
      rx_valid_q  <= 1'b0;
      frame_end_q <= stop;
      tx_req_q    <= consume;

      unique case (1'b1)
        stop: begin
          bit_cnt_q <= 3'd0;
        end
        start: begin
          bit_cnt_q    <= 3'd0;
          byte_count_q <= '0;
          first_q      <= 1'b1;
          tx_shift_q   <= full_q ? buf_q : 8'hFF;
          underrun_q   <= ~full_q;
        end
        rx_edge: begin
          rx_shift_q <= {rx_shift_q[5:0], spi_si};
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_q    <= {rx_shift_q, spi_si};
            rx_valid_q   <= 1'b1;
            rx_first_q   <= first_q;
            first_q      <= 1'b0;
            byte_count_q <= byte_count_q + CNT_W'(1);
          end
        end
        tx_edge: begin
          if (bit_cnt_q == 3'd0) begin
            tx_shift_q <= full_q ? buf_q : 8'hFF;
            if (!full_q) begin
              underrun_q <= 1'b1;
            end
          end else begin
            tx_shift_q <= {tx_shift_q[6:0], 1'b0};
          end
        end
        default: ;
      endcase

      // Load after consume: the old byte leaves, the new one lands
      if (tx_load) begin
        buf_q  <= tx_data;
        full_q <= 1'b1;
      end else if (consume) begin
        full_q <= 1'b0;
      end
    end
  end

  assign spi_so       = act ? tx_shift_q[7] : IDLE_SO;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_first     = rx_first_q;
  assign tx_req       = tx_req_q;
  assign tx_underrun  = underrun_q;
  assign frame_active = act;
  assign frame_end    = frame_end_q;
  assign byte_count   = byte_count_q;

endmodule

// File: doc/ctl_spi_byte_engine.md
# ctl_spi_byte_engine

Byte-level SPI mode-0 slave running in the `clk` domain, placed directly downstream of the `slow_edge_refine` instances on the control SPI port and upstream of the controller's command decoder. It detects edges on the already-refined SCK/CS, deserialises MOSI into bytes, serialises a double-buffered TX byte onto MISO, and reports frame boundaries and per-frame byte index. It replaces ad-hoc bit shifting inside the controller.

## Interface
- `CNT_W`, 16, width of per-frame byte counter
- `IDLE_SO`, 1'b1, MISO level while CS is high
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `spi_sck`  in  1  refined SCK (already synchronised to `clk`)
- `spi_cs`  in  1  refined CS, active low
- `spi_si`  in  1  MOSI, sampled only on detected SCK rising edge
- `spi_so`  out  1  MISO
- `rx_data`  out  8  last completed received byte
- `rx_valid`  out  1  one-cycle pulse, `rx_data` new
- `rx_first`  out  1  qualifies `rx_valid`: byte is first of frame
- `tx_data`  in  8  next byte to transmit
- `tx_load`  in  1  write `tx_data` into TX buffer
- `tx_req`  out  1  one-cycle pulse: TX buffer consumed, refill wanted
- `tx_underrun`  out  1  sticky: byte started with empty buffer
- `frame_active`  out  1  high between detected CS fall and CS rise
- `frame_end`  out  1  one-cycle pulse on detected CS rise
- `byte_count`  out  CNT_W  completed bytes in current frame

## Operation
- Registers `sck_q`, `cs_q` hold previous samples; `sck_rise = spi_sck & ~sck_q`, `sck_fall = ~spi_sck & sck_q`, `cs_fall = ~spi_cs & cs_q`, `cs_rise = spi_cs & ~cs_q`.
- States: IDLE (CS high), ACTIVE. IDLE -> ACTIVE on `cs_fall`; ACTIVE -> IDLE on `cs_rise`.
- On `cs_fall`: `bit_cnt`=0, `byte_count`=0, `tx_underrun` cleared, first-byte flag set, `tx_shift` loaded from TX buffer (0xFF and `tx_underrun`=1 if buffer empty), buffer marked empty, `tx_req` pulsed.
- ACTIVE, `sck_rise`: `rx_shift` <= {`rx_shift[6:0]`, `spi_si`}, `bit_cnt`++ (3-bit, wraps). When `bit_cnt` was 7: `rx_data` <= {`rx_shift[6:0]`, `spi_si`}, `rx_valid`=1, `rx_first`=first flag, first flag cleared, `byte_count`++ (wraps mod 2^CNT_W).
- ACTIVE, `sck_fall`: if `bit_cnt`==0 (byte boundary, not the first byte) reload `tx_shift` from buffer exactly as on `cs_fall` (underrun sets sticky flag), pulse `tx_req`; otherwise `tx_shift` <= {`tx_shift[6:0]`, 1'b0}.
- MSB first; `spi_so` = `tx_shift[7]` in ACTIVE, `IDLE_SO` in IDLE.
- TX buffer: `tx_load` writes buffer and sets full; writing while full overwrites. Same-cycle consume and `tx_load`: consume takes old content, then new data written, buffer ends full.
- `cs_rise` mid-byte: partial bits discarded, no `rx_valid`, `bit_cnt`=0, `frame_end` pulsed; `byte_count` held until next `cs_fall`; TX buffer content retained.
- Priority: `cs_rise` > `cs_fall` > SCK edges; SCK edges in IDLE or in the `cs_fall` cycle are ignored.
- `rst`: all state to IDLE values; TX buffer empty.

## Timing
- Reset values: `spi_so`=`IDLE_SO`, `rx_data`=0, `rx_valid`=0, `rx_first`=0, `tx_req`=0, `tx_underrun`=0, `frame_active`=0, `frame_end`=0, `byte_count`=0.
- `frame_active`, `tx_req`, `spi_so` first bit: valid the cycle after `cs_fall` is seen.
- `rx_valid`/`rx_data`/`byte_count`: registered, valid 1 cycle after the 8th `sck_rise` detection.
- `spi_so` updates 1 cycle after `sck_fall` detection; host SCK half-period must be ≥ 4 `clk` cycles including refine latency.
- `frame_end`: 1 cycle after `cs_rise` detection; `frame_active` falls same cycle.

## Test plan
- Reset, CS low, 1 byte MOSI 0xA5 with TX buffer 0x3C -> `rx_data`=0xA5, `rx_valid` once with `rx_first`=1, MISO bits 0,0,1,1,1,1,0,0, `byte_count`=1.
- 3-byte frame 0x01,0x02,0x03; `tx_load` 0x11,0x22,0x33 answering each `tx_req` -> MISO 0x11,0x22,0x33, `rx_first` only on byte 0, `byte_count`=3, `frame_end` one pulse.
- Second byte with no `tx_load` after `tx_req` -> MISO 0xFF, `tx_underrun`=1 held until next `cs_fall`.
- CS rise after 5 bits -> no `rx_valid`, `frame_end` pulse; next frame byte 0x5A received correctly with `rx_first`=1.
- SCK toggling with CS high -> no `rx_valid`, `spi_so`=`IDLE_SO`, counters unchanged.
- `rst` asserted mid-byte -> all outputs at reset values next cycle; subsequent frame 0xC3 received correctly.
